// File: rtl/mod503_chunk_accum.sv
// rtl/mod503_chunk_accum.sv - modular chunk accumulator (IDLE/ACC/DONE) with handshaked result
// Optional input range check enabled by MOD503_ACCUM_RANGECHK_EN.
module mod503_chunk_accum #(
    parameter int MOD = 503,
    parameter int W   = 9,
    parameter int CW  = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_res,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_res,
    output logic [CW-1:0] out_cnt,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [W:0]    MOD_W1  = (W+1)'(MOD);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          accept;
    logic          in_over;
    logic [W-1:0]  op;
    logic [W:0]    sum;
    logic [W:0]    sum_red;

    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;

    // Operand conditioning: out-of-range residues are folded once before use.
    always_comb begin
`ifdef MOD503_ACCUM_RANGECHK_EN
        in_over = ({1'b0, in_res} >= MOD_W1);
        op      = in_over ? W'({1'b0, in_res} - MOD_W1) : in_res;
`else
        in_over = 1'b0;
        op      = in_res;
`endif
    end

    // Both addends are below MOD, so one conditional subtraction suffices.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, op};
        sum_red = (sum >= MOD_W1) ? (sum - MOD_W1) : sum;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (accept & in_over);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = op;
                    cnt_d   = CW'(1);
                    state_d = in_last ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d   = sum_red[W-1:0];
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    state_d = in_last ? S_DONE : S_ACC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Result bus reads zero whenever no result is being offered.
    assign out_res = out_valid ? acc_q : '0;
    assign out_cnt = out_valid ? cnt_q : '0;
    assign err     = err_q;

endmodule

// File: doc/mod503_chunk_accum.md
MOD503_CHUNK_ACCUM -- requirements
Module: mod503_chunk_accum

Interface
REQ-001 Parameter MOD, default 503, modulus; SHALL satisfy 2 <= MOD <= 511.
REQ-002 Parameter W, default 9, residue width in bits.
REQ-003 Parameter CW, default 7, chunk-counter width in bits.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_res/in_last are valid this cycle.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_res  input  W  partial residue from one 6-bit-chunk LUT stage, nominally < MOD.
REQ-009 in_last  input  1  final chunk of the current operand.
REQ-010 out_valid  output  1  out_res/out_cnt hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_res  output  W  sum of all frame beats, reduced mod MOD.
REQ-013 out_cnt  output  CW  number of beats in the frame, saturating at 2^CW-1.
REQ-014 err  output  1  sticky range-error flag (see Configuration).

Function
REQ-015 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-016 States SHALL be IDLE, ACC and DONE; in_ready SHALL be 1 in IDLE and ACC and 0 in DONE.
REQ-017 IDLE: an accepted beat SHALL load acc=in_res and cnt=1; the next state SHALL be DONE if in_last=1, else ACC.
REQ-018 ACC: an accepted beat SHALL form s=acc+in_res at W+1 bits and set acc=s-MOD if s>=MOD, else s; cnt SHALL increment, saturating at 2^CW-1.
REQ-019 ACC: an accepted beat with in_last=1 SHALL move to DONE; with no accepted beat the state SHALL hold.
REQ-020 out_valid SHALL equal 1 exactly in DONE, with out_res=acc and out_cnt=cnt stable until the handshake completes.
REQ-021 Latency: for a last beat accepted at edge t, out_valid SHALL be 1 in the cycle after edge t.
REQ-022 DONE with out_ready=1: the next state SHALL be IDLE; because in_ready=0 in DONE, no beat SHALL be accepted in the same cycle.
REQ-023 DONE with out_ready=0: all outputs SHALL hold with no limit on stall length.
REQ-024 A single-beat frame (in_last=1 in IDLE) SHALL yield out_res=in_res mod MOD and out_cnt=1.
REQ-025 The block SHALL sustain one accepted beat per cycle in ACC; a frame of N beats SHALL occupy N+1 cycles minimum, including the output cycle.
REQ-026 The accumulator SHALL be reduced with one conditional subtraction, given that operand inputs are < MOD.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, acc=0, cnt=0, err=0.
REQ-028 Output values during and after reset: out_valid=0, out_res=0, out_cnt=0, in_ready=1 from the first cycle after reset.
REQ-029 Reset asserted mid-frame or in DONE SHALL discard the partial or pending result with no output handshake.

Configuration
REQ-030 Macro MOD503_ACCUM_RANGECHK_EN.
REQ-031 Defined: an accepted beat with in_res>=MOD SHALL set err=1 until reset; that beat SHALL first be reduced by one conditional subtraction of MOD before accumulation.
REQ-032 Not defined: err SHALL be driven 0 and in_res SHALL be used unchecked; results for in_res>=MOD are unspecified.

Verification
REQ-033 Beats 502 then 502 (last) -> out_res=501, out_cnt=2, out_valid in the cycle after the last beat.
REQ-034 Beats 250 then 253 (last) -> out_res=0 (wrap to zero); single beat 0 (last) -> out_res=0, out_cnt=1.
REQ-035 84 back-to-back beats of value 6 -> out_res=504 mod 503=1, out_cnt=84, in_ready=1 throughout the frame.
REQ-036 Result pending with out_ready=0 for 5 cycles -> out_res, out_cnt and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-037 rst pulse after 3 of 5 beats -> no out_valid; a following frame of 10 then 20 (last) -> out_res=30, out_cnt=2.
REQ-038 With MOD503_ACCUM_RANGECHK_EN, beat 505 (last) -> err=1 (sticky), out_res=2; without the macro, err stays 0.
